// File: rtl/match_sched.sv
// match_sched: round-robin scheduler sharing one pattern detector among NUM_SRC byte sources (optional MATCH_CNT_EN per-source match counters)
module match_sched #(
  parameter int NUM_SRC   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [NUM_SRC*8-1:0] src_data,
  input  logic [NUM_SRC-1:0]   src_last,
  output logic [NUM_SRC-1:0]   src_ready,
  output logic [7:0]           det_data,
  input  logic                 det_flag,
  output logic                 match_valid,
  output logic [2:0]           match_src,
  output logic                 busy,
  input  logic [2:0]           cnt_sel,
  output logic [15:0]          cnt_rdata
);
  localparam int GW = $clog2(NUM_SRC);
  localparam int BW = $clog2(MAX_BURST + 1);
  typedef enum logic [1:0] {IDLE, XFER, FLUSH} state_t;
  state_t state, state_nx;
  logic [GW-1:0] g, win;
  logic any, hs, done;
  logic [BW-1:0] cnt;
  logic [GW:0] tag1, tag2;
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb begin
    win = g;
    any = 1'b0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      if (src_valid[GW'((int'(g) + k) % NUM_SRC)]) begin
        win = GW'((int'(g) + k) % NUM_SRC);
        any = 1'b1;
      end
    end
    hs = state == XFER && src_valid[g];
    done = !src_valid[g] || src_last[g] || cnt == BW'(MAX_BURST - 1);
    state_nx = state == XFER ? (done ? FLUSH : XFER) : (any ? XFER : IDLE);
  end
  always_comb begin
    src_ready = hs ? NUM_SRC'(1) << g : '0;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      g <= GW'(NUM_SRC - 1);
      cnt <= '0;
      det_data <= 8'h00;
      tag1 <= '0;
      tag2 <= '0;
      match_valid <= 1'b0;
      match_src <= '0;
    end else begin
      g <= state != XFER && any ? win : g;
      cnt <= state == XFER && !done ? cnt + 1'b1 : '0;
      det_data <= hs ? src_data[{g, 3'b000} +: 8] : 8'h00;
      tag1 <= {hs, g};
      tag2 <= tag1;
      match_valid <= det_flag && tag2[GW];
      match_src <= 3'(tag2[GW-1:0]);
    end
  end
`ifdef MATCH_CNT_EN
  logic [15:0] cnt_q [NUM_SRC];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
      cnt_rdata <= '0;
    end else begin
      if (match_valid && cnt_q[match_src[GW-1:0]] != 16'hFFFF)
        cnt_q[match_src[GW-1:0]] <= cnt_q[match_src[GW-1:0]] + 16'd1;
      cnt_rdata <= int'(cnt_sel) < NUM_SRC ? cnt_q[cnt_sel[GW-1:0]] : 16'h0000;
    end
  end
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel;
  assign cnt_rdata = 16'h0000;
`endif
endmodule
